// File: rtl/decode_issue_buffer_pkg.sv
// Shared fetch/decode pipeline definitions: default datapath widths and the
// entry record that travels from fetch into the decode issue buffer.
package decode_issue_buffer_pkg;

   localparam int ADDR_WIDTH        = 32;
   localparam int INSTRUCTION_WIDTH = 32;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]        program_count;
      logic [INSTRUCTION_WIDTH-1:0] instruction_data;
      logic                         instruction_data_valid;
   } fetch_entry_t;

   // Pointer width for a power-of-two circular buffer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/decode_issue_buffer_if.sv
// Fetch-side and decode-side done/stall handshake bundle of the issue buffer.
// master = pipeline neighbours (fetch + decode), slave = the buffer itself.
interface decode_issue_buffer_if #(
   parameter int ADDR_WIDTH        = decode_issue_buffer_pkg::ADDR_WIDTH,
   parameter int INSTRUCTION_WIDTH = decode_issue_buffer_pkg::INSTRUCTION_WIDTH
) ();

   logic                         prev_done;
   logic                         stall_prev;
   logic [ADDR_WIDTH-1:0]        program_count;
   logic [INSTRUCTION_WIDTH-1:0] instruction_data;
   logic                         instruction_data_valid;

   logic                         done_next;
   logic                         next_stall;
   logic [ADDR_WIDTH-1:0]        head_program_count;
   logic [INSTRUCTION_WIDTH-1:0] head_instruction_data;
   logic                         head_instruction_data_valid;

   modport master (
      output prev_done, program_count, instruction_data, instruction_data_valid, next_stall,
      input  stall_prev, done_next, head_program_count, head_instruction_data,
             head_instruction_data_valid
   );

   modport slave (
      input  prev_done, program_count, instruction_data, instruction_data_valid, next_stall,
      output stall_prev, done_next, head_program_count, head_instruction_data,
             head_instruction_data_valid
   );

endinterface

// File: rtl/decode_issue_buffer_sat_counter.sv
// Saturating accumulator: adds a variable amount when enabled and sticks at
// all-ones instead of wrapping.
module decode_issue_buffer_sat_counter #(
   parameter int WIDTH     = 16,
   parameter int INC_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [INC_WIDTH-1:0] inc,
   output logic [WIDTH-1:0]     value
);

   localparam int SUM_WIDTH = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

   logic [WIDTH-1:0]     value_q;
   logic [WIDTH-1:0]     value_d;
   logic [SUM_WIDTH-1:0] sum;

   always_comb begin
      sum     = SUM_WIDTH'(value_q) + SUM_WIDTH'(inc);
      value_d = value_q;
      if (en) begin
         value_d = (sum[SUM_WIDTH-1:WIDTH] != '0) ? '1 : sum[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/decode_issue_buffer.sv
// In-order instruction queue between fetch and decode with optional empty-queue
// fall-through and a whole-queue flush on redirect.
module decode_issue_buffer #(
   parameter int ADDR_WIDTH         = decode_issue_buffer_pkg::ADDR_WIDTH,
   parameter int INSTRUCTION_WIDTH  = decode_issue_buffer_pkg::INSTRUCTION_WIDTH,
   parameter int DEPTH              = 4,
   parameter int FALLTHROUGH        = 0,
   parameter int STAT_WIDTH         = 16,
   localparam int COUNT_WIDTH       = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   decode_issue_buffer_if.slave   bus,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [STAT_WIDTH-1:0]  flushed_entries
);

   import decode_issue_buffer_pkg::*;

   localparam int                     PTR_WIDTH  = ptr_width(DEPTH);
   localparam bit                     BYPASS_EN  = (FALLTHROUGH != 0);
   localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]        program_count;
      logic [INSTRUCTION_WIDTH-1:0] instruction_data;
      logic                         instruction_data_valid;
   } entry_t;

   entry_t                 storage_q [DEPTH];
   logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   logic   empty;
   logic   full;
   logic   done_next;
   logic   stall_prev;
   logic   transfer_prev;
   logic   transfer_next;
   logic   bypass;
   logic   push;
   logic   pop;
   entry_t in_entry;
   entry_t head_entry;
   logic [COUNT_WIDTH:0] flush_inc;

   assign in_entry = '{
      program_count:          bus.program_count,
      instruction_data:       bus.instruction_data,
      instruction_data_valid: bus.instruction_data_valid
   };

   // Handshake: rst_n gates both outputs so they drop the moment reset asserts,
   // even with a live fall-through offer on the input.
   always_comb begin
      empty         = (count_q == '0);
      full          = (count_q == FULL_COUNT);
      done_next     = rst_n && !flush && (!empty || (BYPASS_EN && bus.prev_done));
      transfer_next = done_next && !bus.next_stall;
      stall_prev    = rst_n && !flush && full && !transfer_next;
      transfer_prev = bus.prev_done && !stall_prev;
      bypass        = BYPASS_EN && empty && transfer_next;
      push          = transfer_prev && !bypass && !flush;
      pop           = transfer_next && !empty;
   end

   always_comb begin
      head_entry = '0;
      if (done_next) begin
         head_entry = empty ? in_entry : storage_q[rd_ptr_q];
      end
   end

   assign bus.done_next                   = done_next;
   assign bus.stall_prev                  = stall_prev;
   assign bus.head_program_count          = head_entry.program_count;
   assign bus.head_instruction_data       = head_entry.instruction_data;
   assign bus.head_instruction_data_valid = head_entry.instruction_data_valid;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + COUNT_WIDTH'(1);
            2'b01:   count_d = count_q - COUNT_WIDTH'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry slots carry no reset; only the slot under wr_ptr is written.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_q == PTR_WIDTH'(gi))) begin
            storage_q[gi] <= in_entry;
         end
      end
   end

   // The offered entry is accepted and dropped during a flush, so it counts too.
   assign flush_inc = {1'b0, count_q} + {{COUNT_WIDTH{1'b0}}, transfer_prev};

   decode_issue_buffer_sat_counter #(
      .WIDTH     (STAT_WIDTH),
      .INC_WIDTH (COUNT_WIDTH + 1)
   ) u_flush_stat (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (flush),
      .inc   (flush_inc),
      .value (flushed_entries)
   );

   assign count = count_q;

endmodule
